// File: rtl/instruction_pkg.sv
// instruction_pkg: shared pipeline types for the in-order RISC-V core.
//   ID_W      - width of instruction IDs carried through the pipeline
//   REG_IDX_W - architectural register index width
//   stage_info_t - per-stage valid, ID and destination/load side info
package instruction_pkg;
   localparam int ID_W = 32;
   localparam int REG_IDX_W = 5;
   typedef struct packed {
      logic                 v;
      logic [ID_W-1:0]      id;
      logic [REG_IDX_W-1:0] rd;
      logic                 rdv;
      logic                 load;
   } stage_info_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: datapath <-> sequencing-controller bundle.
//   master (datapath): drives fetch_v, I-stage operands (i_rs1/i_rs2/i_rd/i_rdv/i_load),
//                      br_taken and m_busy; observes enables, valids, IDs and kills.
//   slave  (pipe_ctrl): the reverse. x_info/m_info expose the X/M side info
//                      (rd, rdv, load) carried alongside each stage's valid and ID.
//   PIPE_CTRL_PERF_EN adds stall_cnt, flush_cnt and bubble_cnt.
interface pipe_ctrl_if #(
   parameter int ID_W     = instruction_pkg::ID_W,
   parameter int XLEN_REG = instruction_pkg::REG_IDX_W
);
   logic                fetch_v;
   logic [XLEN_REG-1:0] i_rs1;
   logic [XLEN_REG-1:0] i_rs2;
   logic [XLEN_REG-1:0] i_rd;
   logic                i_rdv;
   logic                i_load;
   logic                br_taken;
   logic                m_busy;
   logic                adv_i;
   logic                adv_x;
   logic                adv_m;
   logic                stall_i;
   logic                flush;
   logic                inst_v_i;
   logic                inst_v_x;
   logic                inst_v_m;
   logic                inst_v_r;
   logic [ID_W-1:0]     ci;
   logic [ID_W-1:0]     cx;
   logic [ID_W-1:0]     cm;
   logic [ID_W-1:0]     cr;
   logic                kill_v;
   logic [ID_W-1:0]     kill_id;
   logic [ID_W-1:0]     retired;
   instruction_pkg::stage_info_t x_info;
   instruction_pkg::stage_info_t m_info;
`ifdef PIPE_CTRL_PERF_EN
   logic [ID_W-1:0]     stall_cnt;
   logic [ID_W-1:0]     flush_cnt;
   logic [ID_W-1:0]     bubble_cnt;
`endif

   modport master (
      output fetch_v, i_rs1, i_rs2, i_rd, i_rdv, i_load, br_taken, m_busy,
      input  adv_i, adv_x, adv_m, stall_i, flush,
      input  inst_v_i, inst_v_x, inst_v_m, inst_v_r, ci, cx, cm, cr,
      input  kill_v, kill_id, retired, x_info, m_info
`ifdef PIPE_CTRL_PERF_EN
      , input stall_cnt, flush_cnt, bubble_cnt
`endif
   );

   modport slave (
      input  fetch_v, i_rs1, i_rs2, i_rd, i_rdv, i_load, br_taken, m_busy,
      output adv_i, adv_x, adv_m, stall_i, flush,
      output inst_v_i, inst_v_x, inst_v_m, inst_v_r, ci, cx, cm, cr,
      output kill_v, kill_id, retired, x_info, m_info
`ifdef PIPE_CTRL_PERF_EN
      , output stall_cnt, flush_cnt, bubble_cnt
`endif
   );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: combinational hold / load-use / flush resolution.
//   in : i_v, x_v, x_rd, x_rdv, x_load, m_v, i_rs1, i_rs2, br_taken, m_busy
//   out: hold_m, flush, stall_i, adv_i, adv_x, adv_m
module pipe_ctrl_hazard #(
   parameter int XLEN_REG = 5
) (
   input  logic                i_v,
   input  logic                x_v,
   input  logic [XLEN_REG-1:0] x_rd,
   input  logic                x_rdv,
   input  logic                x_load,
   input  logic                m_v,
   input  logic [XLEN_REG-1:0] i_rs1,
   input  logic [XLEN_REG-1:0] i_rs2,
   input  logic                br_taken,
   input  logic                m_busy,
   output logic                hold_m,
   output logic                flush,
   output logic                stall_i,
   output logic                adv_i,
   output logic                adv_x,
   output logic                adv_m
);
   logic lu;

   always_comb begin
      lu      = i_v & x_v & x_load & x_rdv & (x_rd != '0) & ((i_rs1 == x_rd) | (i_rs2 == x_rd));
      hold_m  = m_v & m_busy;
      // A redirect waits out an M hold; the datapath keeps br_taken and X steady meanwhile.
      flush   = br_taken & x_v & ~hold_m;
      adv_m   = ~hold_m;
      adv_x   = ~hold_m;
      // Flush outranks load-use: the load-use victim is the instruction being killed.
      adv_i   = ~hold_m & ~flush & ~lu;
      stall_i = i_v & (lu | hold_m) & ~flush;
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 4-stage I/X/M/R pipeline.
//   clk, reset (async, active-low) plain ports; everything else on bus (pipe_ctrl_if.slave):
//   stage valids/IDs, stage enables, stall/flush/kill and retire count.
//   Optional macro PIPE_CTRL_PERF_EN adds stall_cnt, flush_cnt, bubble_cnt.
module pipe_ctrl #(
   parameter int ID_W     = instruction_pkg::ID_W,
   parameter int XLEN_REG = instruction_pkg::REG_IDX_W
) (
   input  logic       clk,
   input  logic       reset,
   pipe_ctrl_if.slave bus
);
   import instruction_pkg::stage_info_t;

   logic            iv_q, iv_d, rv_q, rv_d;
   logic [ID_W-1:0] ci_q, ci_d, cr_q, cr_d, nid_q, nid_d, ret_q, ret_d;
   stage_info_t     x_q, x_d, m_q, m_d;
   logic            hold_m, flush, stall_i, adv_i, adv_x, adv_m, fetch_ok;

   pipe_ctrl_hazard #(.XLEN_REG(XLEN_REG)) u_hazard (
      .i_v      (iv_q),
      .x_v      (x_q.v),
      .x_rd     (x_q.rd),
      .x_rdv    (x_q.rdv),
      .x_load   (x_q.load),
      .m_v      (m_q.v),
      .i_rs1    (bus.i_rs1),
      .i_rs2    (bus.i_rs2),
      .br_taken (bus.br_taken),
      .m_busy   (bus.m_busy),
      .hold_m   (hold_m),
      .flush    (flush),
      .stall_i  (stall_i),
      .adv_i    (adv_i),
      .adv_x    (adv_x),
      .adv_m    (adv_m)
   );

   always_comb begin
      // I accepts a fetch only when empty or moving on; the fetch racing a flush is dropped.
      fetch_ok = bus.fetch_v & ~flush & (~iv_q | adv_i);
      iv_d     = fetch_ok | (iv_q & ~adv_i & ~flush);
      ci_d     = fetch_ok ? nid_q : ci_q;
      nid_d    = nid_q + ID_W'(fetch_ok);
      x_d      = x_q;
      if (adv_i)
         x_d = '{v: iv_q, id: ci_q, rd: bus.i_rd, rdv: bus.i_rdv, load: bus.i_load};
      else if (adv_x)
         x_d.v = 1'b0;
      m_d      = adv_x ? x_q : m_q;
      rv_d     = adv_m & m_q.v;
      cr_d     = adv_m ? m_q.id : cr_q;
      ret_d    = ret_q + ID_W'(rv_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iv_q  <= 1'b0;
         rv_q  <= 1'b0;
         ci_q  <= '0;
         cr_q  <= '0;
         nid_q <= '0;
         ret_q <= '0;
         x_q   <= '0;
         m_q   <= '0;
      end else begin
         iv_q  <= iv_d;
         rv_q  <= rv_d;
         ci_q  <= ci_d;
         cr_q  <= cr_d;
         nid_q <= nid_d;
         ret_q <= ret_d;
         x_q   <= x_d;
         m_q   <= m_d;
      end
   end

   assign bus.adv_i    = adv_i;
   assign bus.adv_x    = adv_x;
   assign bus.adv_m    = adv_m;
   assign bus.stall_i  = stall_i;
   assign bus.flush    = flush;
   assign bus.inst_v_i = iv_q;
   assign bus.inst_v_x = x_q.v;
   assign bus.inst_v_m = m_q.v;
   assign bus.inst_v_r = rv_q;
   assign bus.ci       = ci_q;
   assign bus.cx       = x_q.id;
   assign bus.cm       = m_q.id;
   assign bus.cr       = cr_q;
   assign bus.kill_v   = flush & iv_q;
   assign bus.kill_id  = ci_q;
   assign bus.retired  = ret_q;
   assign bus.x_info   = x_q;
   assign bus.m_info   = m_q;

`ifdef PIPE_CTRL_PERF_EN
   logic            seen_q, seen_d;
   logic [ID_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q + ID_W'(stall_i);
      flush_cnt_d  = flush_cnt_q + ID_W'(flush & iv_q);
      // Bubbles only count once something has retired, so pipeline fill is excluded.
      seen_d       = seen_q | rv_q;
      bubble_cnt_d = bubble_cnt_q + ID_W'(seen_q & ~rv_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seen_q       <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         seen_q       <= seen_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.flush_cnt  = flush_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with an in-order retire scoreboard.
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb[$];
   logic [31:0] sb_exp;

   always #5 clk = ~clk;

   pipe_ctrl_if bus();

   pipe_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.fetch_v  = 1'b0;
      bus.i_rs1    = '0;
      bus.i_rs2    = '0;
      bus.i_rd     = '0;
      bus.i_rdv    = 1'b0;
      bus.i_load   = 1'b0;
      bus.br_taken = 1'b0;
      bus.m_busy   = 1'b0;
   endtask

   task automatic do_reset();
      clr_in();
      reset = 1'b0;
      sb.delete();
      step();
      reset = 1'b1;
   endtask

   task automatic drain(input string tag);
      clr_in();
      repeat (4) step();
      chk(tag, sb.size(), 0);
   endtask

   // Every valid R must carry the next expected ID, in program order.
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.inst_v_r === 1'b1) begin
         sb_exp = (sb.size() > 0) ? sb[0] : 32'hffff_ffff;
         if (sb.size() > 0) sb.pop_front();
         chk("retire_order", bus.cr, sb_exp);
      end
   end

   initial begin
      clr_in();
      reset = 1'b0;
      step();
      step();
      chk("rst_valids", {28'd0, bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r}, 0);
      chk("rst_ci", bus.ci, 0);
      chk("rst_cr", bus.cr, 0);
      chk("rst_retired", bus.retired, 0);
      reset = 1'b1;

      // Straight-line stream of 6 instructions.
      for (int k = 0; k < 6; k++) begin
         bus.fetch_v = 1'b1;
         sb.push_back(k);
         step();
         chk("stream_ci", bus.ci, k);
         if (k == 2) chk("stream_r_not_yet", bus.inst_v_r, 0);
         if (k == 3) chk("stream_first_r", {bus.inst_v_r, bus.cr[30:0]}, 32'h8000_0000);
      end
      chk("stream_retired3", bus.retired, 3);
      drain("stream_drain");
      chk("stream_retired6", bus.retired, 6);

      // Load x5 then consumer of x5: one stall cycle.
      do_reset();
      bus.fetch_v = 1'b1;
      sb.push_back(0);
      step();
      bus.i_rd = 5; bus.i_rdv = 1'b1; bus.i_load = 1'b1;
      sb.push_back(1);
      step();
      bus.i_rs1 = 5; bus.i_rs2 = 1; bus.i_rd = 6; bus.i_rdv = 1'b1; bus.i_load = 1'b0;
      #1;
      chk("lu_stall", bus.stall_i, 1);
      chk("lu_adv_i", bus.adv_i, 0);
      step();
      chk("lu_hold_ci", bus.ci, 1);
      chk("lu_bubble_x", bus.inst_v_x, 0);
      chk("lu_cm", bus.cm, 0);
      chk("lu_stall_clear", bus.stall_i, 0);
      sb.push_back(2);
      step();
      chk("lu_cx_late", bus.cx, 1);
      chk("lu_ci_next", bus.ci, 2);
      drain("lu_drain");

      // Load writing x0 followed by a reader of x0: no stall.
      bus.fetch_v = 1'b1;
      sb.push_back(3);
      step();
      bus.i_rd = 0; bus.i_rdv = 1'b1; bus.i_load = 1'b1;
      sb.push_back(4);
      step();
      bus.fetch_v = 1'b0;
      bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_rd = 7; bus.i_load = 1'b0;
      #1;
      chk("x0_no_stall", bus.stall_i, 0);
      chk("x0_adv_i", bus.adv_i, 1);
      step();
      chk("x0_cx", bus.cx, 4);
      drain("x0_drain");

      // Branch with ID 2 in X kills ID 3 in I.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         bus.fetch_v = 1'b1;
         if (k != 3) sb.push_back(k);
         step();
      end
      bus.br_taken = 1'b1;
      #1;
      chk("br_flush", bus.flush, 1);
      chk("br_kill_v", bus.kill_v, 1);
      chk("br_kill_id", bus.kill_id, 3);
      chk("br_adv_i", bus.adv_i, 0);
      step();
      chk("br_i_empty", bus.inst_v_i, 0);
      chk("br_x_bubble", bus.inst_v_x, 0);
      chk("br_cm", bus.cm, 2);
      bus.br_taken = 1'b0;
      #1;
      chk("br_kill_clear", bus.kill_v, 0);
      sb.push_back(4);
      step();
      chk("br_next_id", bus.ci, 4);
      bus.fetch_v = 1'b0;
      step();
      chk("br_cx", bus.cx, 4);
      drain("br_drain");

      // M busy for three cycles with ID 1 in M.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         bus.fetch_v = 1'b1;
         sb.push_back(k);
         step();
      end
      bus.m_busy = 1'b1;
      #1;
      chk("busy_stall", bus.stall_i, 1);
      chk("busy_adv_m", bus.adv_m, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("busy_frozen", {8'd0, bus.ci[7:0], bus.cx[7:0], bus.cm[7:0]}, 32'h0003_0201);
         chk("busy_r_bubble", bus.inst_v_r, 0);
      end
      bus.m_busy = 1'b0;
      sb.push_back(4);
      step();
      chk("busy_release_r", {bus.inst_v_r, bus.cr[30:0]}, 32'h8000_0001);
      chk("busy_release_ci", bus.ci, 4);
      drain("busy_drain");

      // Load-use and branch in the same cycle: flush wins.
      do_reset();
      bus.fetch_v = 1'b1;
      sb.push_back(0);
      step();
      bus.i_rd = 5; bus.i_rdv = 1'b1; bus.i_load = 1'b1;
      step();
      bus.i_rs1 = 5; bus.i_rd = 0; bus.i_rdv = 1'b0; bus.i_load = 1'b0;
      bus.br_taken = 1'b1;
      #1;
      chk("lubr_flush", bus.flush, 1);
      chk("lubr_no_stall", bus.stall_i, 0);
      chk("lubr_kill_id", bus.kill_id, 1);
      step();
      chk("lubr_i_empty", bus.inst_v_i, 0);
      bus.br_taken = 1'b0;
      bus.i_rs1 = 0;
      sb.push_back(2);
      step();
      chk("lubr_next_id", bus.ci, 2);
      drain("lubr_drain");

      // Asynchronous reset with all four stages full.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         bus.fetch_v = 1'b1;
         sb.push_back(k);
         step();
      end
      chk("full_valids", {28'd0, bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r}, 32'hf);
      #3;
      reset = 1'b0;
      sb.delete();
      #1;
      chk("arst_valids", {28'd0, bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r}, 0);
      chk("arst_ci", bus.ci, 0);
      chk("arst_retired", bus.retired, 0);
      step();
      reset = 1'b1;
      bus.fetch_v = 1'b1;
      sb.push_back(0);
      step();
      chk("arst_next_id", {bus.inst_v_i, bus.ci[30:0]}, 32'h8000_0000);
      drain("arst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Sequencing controller for the 4-stage in-order RISC-V pipeline (I, X, M, R).
- Tracks per-stage valid bits and instruction IDs, detects load-use hazards, and applies stalls and branch flushes.
- Drives the stage-valid and ID signals consumed by the trace/Konata logger and by the datapath stage enables.

Parameters:
- ID_W, 32, width of instruction ID counter and stage ID outputs.
- XLEN_REG, 5, register index width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous reset, active-low (0 = in reset)
- fetch_v  in  1  fetched instruction presented to I this cycle
- i_rs1  in  5  rs1 of instruction in I
- i_rs2  in  5  rs2 of instruction in I
- i_rd  in  5  rd of instruction in I
- i_rdv  in  1  instruction in I writes rd
- i_load  in  1  instruction in I is a load
- br_taken  in  1  X-stage branch/jump redirect (pcv)
- m_busy  in  1  M stage cannot complete this cycle
- adv_i, adv_x, adv_m  out  1  stage register enables (I->X, X->M, M->R)
- stall_i  out  1  fetch must hold current instruction
- flush  out  1  younger instruction in I is killed this cycle
- inst_v_i, inst_v_x, inst_v_m, inst_v_r  out  1  stage valid
- ci, cx, cm, cr  out  ID_W  instruction ID held in each stage
- kill_v  out  1  an ID was squashed this cycle
- kill_id  out  ID_W  squashed ID
- retired  out  ID_W  count of instructions leaving R

Behaviour:
- Reset (async, reset==0): all valids 0; all IDs 0; next_id 0; retired 0; all scoreboard flags cleared. Outputs are registered except adv_*, stall_i, flush, kill_v, kill_id (combinational from state + inputs).
- hold_m = inst_v_m & m_busy. While asserted, M, X and I all hold; R receives a bubble; adv_m=adv_x=adv_i=0.
- Load-use: lu = inst_v_i & inst_v_x & x_load & x_rdv & (x_rd!=0) & (i_rs1==x_rd | i_rs2==x_rd).
  - When lu & !hold_m: I holds, X advances to M, and a bubble enters X.
  - No other forwarding hazards are stalled; the datapath forwards them.
- Flush: applies when br_taken & inst_v_x & !hold_m.
  - I-stage instruction, if valid, is invalidated (flush=1, kill_v=1, kill_id=ci) and a bubble enters X.
  - fetch_v in the same cycle is ignored; the target is fetched the next cycle.
  - Flush has priority over lu, because the lu victim is the killed instruction.
- Entry into I: when I is empty or advancing (not held), fetch_v loads inst_v_i=1, ci=next_id, next_id+1.
  - next_id wraps modulo 2^ID_W.
  - A killed ID is not reused.
- stall_i = inst_v_i & (lu | hold_m) & !flush.
- R: inst_v_r is valid for exactly 1 cycle per instruction; retired increments on each valid R (wraps).
- Per-stage side info: rd, rdv and load are copied alongside valid/ID for X and M.
- br_taken with inst_v_x=0 is ignored.
- Simultaneous hold_m & br_taken: the flush is deferred until hold_m clears. br_taken must remain asserted until then (datapath holds X).

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs stall_cnt, flush_cnt, bubble_cnt (ID_W each, reset 0, wrap).
  - stall_cnt counts cycles with stall_i=1.
  - flush_cnt counts kill_v=1 cycles.
  - bubble_cnt counts cycles with inst_v_r=0 after the first retire.
- Undefined: ports and counters absent; core behaviour unchanged.

Decomposition:
- Add a stage_info_t struct {v, id, rd, rdv, load} to shared pipeline package instruction_pkg, together with ID_W.
- One sub-module is natural: pipe_ctrl_hazard, the combinational lu/flush/hold resolution.
- pipe_ctrl keeps the stage registers and counters.

Test Plan:
- Reset, then fetch_v=1 for 6 cycles, no hazards -> ci=0..5 in order; inst_v_r first asserts cycle 4 with cr=0; retired=3 after cycle 6.
- Load x5 (ID 0) then add x6,x5,x1 (ID 1) -> one cycle stall_i=1, bubble in X; cx=1 one cycle later than unhazarded; rd x0 load variant -> no stall.
- br_taken with ID 2 in X, ID 3 in I -> flush=1, kill_v=1, kill_id=3; next fetched ID=4; ID 3 never reaches X.
- m_busy=1 for 3 cycles with ID 1 in M -> ci/cx/cm frozen, inst_v_r=0 for 3 cycles, then cr=1.
- Load-use and br_taken same cycle -> flush wins, stall_i=0; kill_id=ci.
- reset low mid-stream with 4 valid stages -> all valids 0 immediately (async), next_id=0 after release.
